easyaxi_mst_rd: RTL and testbench

- AXI read master: the initiator counterpart of the EasyAXI read slave (AR/R channels only).
- Accepts read commands on a simple valid/ready command port and issues them as AR requests.
- Tracks up to OST_DEPTH outstanding bursts in order, receives R beats, and checks RLAST against the issued length.
- Forwards each beat to a registered user data port and keeps sticky error flags and a completion counter for the bench and SoC status.

---
 rtl/easyaxi_mst_rd_pkg.sv | 28 ++
 rtl/easyaxi_mst_rd_if.sv | 27 ++
 rtl/easyaxi_mst_ost_fifo.sv | 51 +++++
 rtl/easyaxi_mst_rd.sv | 145 ++++++++++++++
 tb/tb_easyaxi_mst_rd.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/easyaxi_mst_rd_pkg.sv
// Shared AXI widths, encodings and the outstanding-burst record for the read master.
package easyaxi_mst_rd_pkg;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_RSV   = 2'b11;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OK     = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOK   = 2'b01;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // One in-flight burst: which ID it carries and how many beats it should return.
  typedef struct packed {
    logic [AXI_ID_W-1:0]  id;
    logic [AXI_LEN_W-1:0] len;
  } ost_entry_t;

endpackage

// File: rtl/easyaxi_mst_rd_if.sv
// AXI read-address and read-data channels between the read master and a slave.
interface easyaxi_mst_rd_if;
  import easyaxi_mst_rd_pkg::*;

  logic                   arvalid;
  logic                   arready;
  logic [AXI_ID_W-1:0]    arid;
  logic [AXI_ADDR_W-1:0]  araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic                   rvalid;
  logic                   rready;
  logic [AXI_DATA_W-1:0]  rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/easyaxi_mst_ost_fifo.sv
// In-order FIFO of outstanding bursts; the head is the burst currently returning R beats.
module easyaxi_mst_ost_fifo
  import easyaxi_mst_rd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  ost_entry_t               push_data_i,
  input  logic                     pop_i,
  output ost_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  ost_entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/easyaxi_mst_rd.sv
// AXI read master: turns commands into AR requests, tracks bursts in order and checks R beats.
module easyaxi_mst_rd
  import easyaxi_mst_rd_pkg::*;
#(
  parameter int unsigned OST_DEPTH  = 4,
  parameter int unsigned DONE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    rd_stall,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AXI_ID_W-1:0]     cmd_id,
  input  logic [AXI_ADDR_W-1:0]   cmd_addr,
  input  logic [AXI_LEN_W-1:0]    cmd_len,
  input  logic [AXI_SIZE_W-1:0]   cmd_size,
  input  logic [AXI_BURST_W-1:0]  cmd_burst,
  easyaxi_mst_rd_if.master        axi_mst,
  output logic                    usr_rd_valid,
  output logic [AXI_DATA_W-1:0]   usr_rd_data,
  output logic [AXI_RESP_W-1:0]   usr_rd_resp,
  output logic                    usr_rd_last,
  output logic [AXI_ID_W-1:0]     usr_rd_id,
  output logic [4:0]              ost_cnt,
  output logic [DONE_CNT_W-1:0]   done_cnt,
  output logic                    err_last,
  output logic                    err_resp
);

  logic                    arvalid_q;
  logic [AXI_ID_W-1:0]     arid_q;
  logic [AXI_ADDR_W-1:0]   araddr_q;
  logic [AXI_LEN_W-1:0]    arlen_q;
  logic [AXI_SIZE_W-1:0]   arsize_q;
  logic [AXI_BURST_W-1:0]  arburst_q;
  logic [AXI_LEN_W-1:0]    beat_cnt_q;
  logic [DONE_CNT_W-1:0]   done_cnt_q;
  logic                    err_last_q, err_resp_q;
  logic                    usr_valid_q, usr_last_q;
  logic [AXI_DATA_W-1:0]   usr_data_q;
  logic [AXI_RESP_W-1:0]   usr_resp_q;
  logic [AXI_ID_W-1:0]     usr_id_q;

  ost_entry_t                   head;
  logic                         fifo_full, fifo_empty;
  logic [$clog2(OST_DEPTH):0]   fifo_cnt;
  logic                         cmd_hs, ar_hs, r_hs, r_done, last_bad;

  // Only one AR can be pending, so a new command waits until the previous one is issued.
  assign cmd_ready = enable & ~arvalid_q & ~fifo_full;
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign ar_hs     = arvalid_q & axi_mst.arready;
  assign axi_mst.rready = ~fifo_empty & ~rd_stall;
  assign r_hs      = axi_mst.rvalid & axi_mst.rready;
  assign r_done    = r_hs & axi_mst.rlast;
  // RLAST must coincide exactly with the beat whose index equals the issued length.
  assign last_bad  = axi_mst.rlast ? (beat_cnt_q != head.len) : (beat_cnt_q == head.len);

  easyaxi_mst_ost_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_ost_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_hs),
    .push_data_i ('{id: cmd_id, len: cmd_len}),
    .pop_i       (r_done),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  // AR request register: loaded on command accept, held until the slave takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else if (cmd_hs) begin
      arvalid_q <= 1'b1;
      arid_q    <= cmd_id;
      araddr_q  <= cmd_addr;
      arlen_q   <= cmd_len;
      arsize_q  <= cmd_size;
      arburst_q <= cmd_burst;
    end else if (ar_hs) begin
      arvalid_q <= 1'b0;
    end
  end

  // R beat tracking, sticky error flags and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      done_cnt_q <= '0;
      err_last_q <= 1'b0;
      err_resp_q <= 1'b0;
    end else if (r_hs) begin
      beat_cnt_q <= axi_mst.rlast ? '0 : beat_cnt_q + 1'b1;
      if (axi_mst.rlast) done_cnt_q <= done_cnt_q + 1'b1;
      if (last_bad) err_last_q <= 1'b1;
      if (axi_mst.rresp != AXI_RESP_OK) err_resp_q <= 1'b1;
    end
  end

  // User port: one registered pulse per accepted beat, tagged with the head burst's ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usr_valid_q <= 1'b0;
      usr_data_q  <= '0;
      usr_resp_q  <= '0;
      usr_last_q  <= 1'b0;
      usr_id_q    <= '0;
    end else begin
      usr_valid_q <= r_hs;
      if (r_hs) begin
        usr_data_q <= axi_mst.rdata;
        usr_resp_q <= axi_mst.rresp;
        usr_last_q <= axi_mst.rlast;
        usr_id_q   <= head.id;
      end
    end
  end

  assign axi_mst.arvalid = arvalid_q;
  assign axi_mst.arid    = arid_q;
  assign axi_mst.araddr  = araddr_q;
  assign axi_mst.arlen   = arlen_q;
  assign axi_mst.arsize  = arsize_q;
  assign axi_mst.arburst = arburst_q;
  assign usr_rd_valid    = usr_valid_q;
  assign usr_rd_data     = usr_data_q;
  assign usr_rd_resp     = usr_resp_q;
  assign usr_rd_last     = usr_last_q;
  assign usr_rd_id       = usr_id_q;
  assign ost_cnt         = 5'(fifo_cnt);
  assign done_cnt        = done_cnt_q;
  assign err_last        = err_last_q;
  assign err_resp        = err_resp_q;

endmodule

// File: tb/tb_easyaxi_mst_rd.sv
// Directed bench for the AXI read master; the bench plays the AXI slave.
module tb_easyaxi_mst_rd;
  import easyaxi_mst_rd_pkg::*;

  localparam int Budget = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1, rd_stall = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [AXI_ID_W-1:0]    cmd_id = '0;
  logic [AXI_ADDR_W-1:0]  cmd_addr = '0;
  logic [AXI_LEN_W-1:0]   cmd_len = '0;
  logic [AXI_SIZE_W-1:0]  cmd_size = '0;
  logic [AXI_BURST_W-1:0] cmd_burst = '0;
  logic                   usr_rd_valid, usr_rd_last, err_last, err_resp;
  logic [AXI_DATA_W-1:0]  usr_rd_data;
  logic [AXI_RESP_W-1:0]  usr_rd_resp;
  logic [AXI_ID_W-1:0]    usr_rd_id;
  logic [4:0]             ost_cnt;
  logic [15:0]            done_cnt;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int ar_cnt = 0;

  easyaxi_mst_rd_if axi ();

  easyaxi_mst_rd #(
    .OST_DEPTH  (4),
    .DONE_CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rd_stall     (rd_stall),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_id       (cmd_id),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_size     (cmd_size),
    .cmd_burst    (cmd_burst),
    .axi_mst      (axi.master),
    .usr_rd_valid (usr_rd_valid),
    .usr_rd_data  (usr_rd_data),
    .usr_rd_resp  (usr_rd_resp),
    .usr_rd_last  (usr_rd_last),
    .usr_rd_id    (usr_rd_id),
    .ost_cnt      (ost_cnt),
    .done_cnt     (done_cnt),
    .err_last     (err_last),
    .err_resp     (err_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (usr_rd_valid) pulses++;
    if (axi.arvalid && axi.arready) ar_cnt++;
  end

  typedef struct {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
    int                     nbeats;
    int                     bad_beat;
    logic                   exp_err_last;
    logic                   exp_err_resp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [AXI_DATA_W-1:0] beat_data(input logic [AXI_ID_W-1:0] id, input int i);
    return {16'hDA7A, 4'h0, id, 8'(i)};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
    chk({tag, "_arid"}, 64'(axi.arid), 64'd0);
    chk({tag, "_araddr"}, 64'(axi.araddr), 64'd0);
    chk({tag, "_arlen"}, 64'(axi.arlen), 64'd0);
    chk({tag, "_rready"}, 64'(axi.rready), 64'd0);
    chk({tag, "_usr_valid"}, 64'(usr_rd_valid), 64'd0);
    chk({tag, "_usr_data"}, 64'(usr_rd_data), 64'd0);
    chk({tag, "_usr_last"}, 64'(usr_rd_last), 64'd0);
    chk({tag, "_ost_cnt"}, 64'(ost_cnt), 64'd0);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
    chk({tag, "_err_last"}, 64'(err_last), 64'd0);
    chk({tag, "_err_resp"}, 64'(err_resp), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    rd_stall = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    axi.rresp = AXI_RESP_OK;
    axi.rdata = '0;
    @(posedge clk); #1;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents a command and waits (bounded) for the handshake edge.
  task automatic issue_cmd(input logic [AXI_ID_W-1:0] id, input logic [AXI_ADDR_W-1:0] addr,
                           input logic [AXI_LEN_W-1:0] len, input logic [AXI_SIZE_W-1:0] size,
                           input logic [AXI_BURST_W-1:0] burst);
    bit got = 0;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    for (int k = 0; k < Budget; k++) begin
      if (cmd_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk("cmd_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Slave side of AR: optional wait states, checking the payload is held while stalled.
  task automatic accept_ar(input logic [AXI_ID_W-1:0] id, input logic [AXI_ADDR_W-1:0] addr,
                           input logic [AXI_LEN_W-1:0] len, input logic [AXI_SIZE_W-1:0] size,
                           input logic [AXI_BURST_W-1:0] burst, input int delay);
    bit got = 0;
    for (int k = 0; k < Budget; k++) begin
      if (axi.arvalid) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk("ar_timeout", 64'd0, 64'd1);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      chk("ar_hold_valid", 64'(axi.arvalid), 64'd1);
      chk("ar_hold_addr", 64'(axi.araddr), 64'(addr));
    end
    chk("arid", 64'(axi.arid), 64'(id));
    chk("araddr", 64'(axi.araddr), 64'(addr));
    chk("arlen", 64'(axi.arlen), 64'(len));
    chk("arsize", 64'(axi.arsize), 64'(size));
    chk("arburst", 64'(axi.arburst), 64'(burst));
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    chk("arvalid_clear", 64'(axi.arvalid), 64'd0);
  endtask

  // Returns beats [first, first+count) of a burst of 'total' beats; RLAST on beat total-1.
  task automatic send_beats(input logic [AXI_ID_W-1:0] id, input int first, input int count,
                            input int total_b, input int bad_beat, input bit toggle);
    for (int i = first; i < first + count; i++) begin
      bit got = 0;
      logic [AXI_RESP_W-1:0] resp;
      resp = (i == bad_beat) ? AXI_RESP_SLVERR : AXI_RESP_OK;
      axi.rdata = beat_data(id, i);
      axi.rresp = resp;
      axi.rlast = (i == total_b - 1);
      axi.rvalid = 1'b1;
      for (int k = 0; k < Budget; k++) begin
        if (toggle) begin rd_stall = ~rd_stall; #1; end
        if (axi.rready) begin got = 1; break; end
        @(posedge clk); #1;
      end
      if (!got) chk("r_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      axi.rvalid = 1'b0;
      axi.rlast = 1'b0;
      chk("usr_valid", 64'(usr_rd_valid), 64'd1);
      chk("usr_data", 64'(usr_rd_data), 64'(beat_data(id, i)));
      chk("usr_resp", 64'(usr_rd_resp), 64'(resp));
      chk("usr_last", 64'(usr_rd_last), 64'(i == total_b - 1));
      chk("usr_id", 64'(usr_rd_id), 64'(id));
    end
    rd_stall = 1'b0;
  endtask

  initial begin
    int base;
    vecs[0] = '{4'd1, 32'h100, 8'd3, 3'd2, AXI_BURST_INCR,  4, -1, 1'b0, 1'b0}; // clean INCR
    vecs[1] = '{4'd2, 32'h200, 8'd3, 3'd2, AXI_BURST_INCR,  2, -1, 1'b1, 1'b0}; // early rlast
    vecs[2] = '{4'd3, 32'h300, 8'd1, 3'd2, AXI_BURST_INCR,  3, -1, 1'b1, 1'b0}; // late rlast
    vecs[3] = '{4'd4, 32'h400, 8'd1, 3'd2, AXI_BURST_INCR,  2,  1, 1'b0, 1'b1}; // SLVERR beat 2
    vecs[4] = '{4'd5, 32'h040, 8'd0, 3'd3, AXI_BURST_FIXED, 1, -1, 1'b0, 1'b0}; // single beat

    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    axi.rresp = AXI_RESP_OK;
    axi.rdata = '0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      base = pulses;
      issue_cmd(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
      accept_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0);
      chk("vec_ost_1", 64'(ost_cnt), 64'd1);
      send_beats(vecs[v].id, 0, vecs[v].nbeats, vecs[v].nbeats, vecs[v].bad_beat, 0);
      chk("vec_done", 64'(done_cnt), 64'd1);
      chk("vec_ost_0", 64'(ost_cnt), 64'd0);
      chk("vec_err_last", 64'(err_last), 64'(vecs[v].exp_err_last));
      chk("vec_err_resp", 64'(err_resp), 64'(vecs[v].exp_err_resp));
      @(posedge clk); #1;
      chk("vec_pulse_end", 64'(usr_rd_valid), 64'd0);
      chk("vec_pulses", 64'(pulses - base), 64'(vecs[v].nbeats));
    end

    // Outstanding full: four ARs go out, the fifth waits for the first burst to finish.
    do_reset();
    base = ar_cnt;
    axi.arready = 1'b1;
    for (int c = 1; c <= 4; c++) issue_cmd(4'(c), 32'(c * 16), 8'd0, 3'd2, AXI_BURST_INCR);
    cmd_id = 4'd5; cmd_addr = 32'h50; cmd_len = 8'd0; cmd_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("full_ost", 64'(ost_cnt), 64'd4);
    chk("full_ar_cnt", 64'(ar_cnt - base), 64'd4);
    send_beats(4'd1, 0, 1, 1, -1, 0);
    issue_cmd(4'd5, 32'h50, 8'd0, 3'd2, AXI_BURST_INCR);
    for (int k = 0; k < Budget && (ar_cnt - base) < 5; k++) begin @(posedge clk); #1; end
    chk("full_ar_cnt5", 64'(ar_cnt - base), 64'd5);
    chk("full_ost_again", 64'(ost_cnt), 64'd4);
    axi.arready = 1'b0;
    for (int c = 2; c <= 5; c++) send_beats(4'(c), 0, 1, 1, -1, 0);
    chk("full_done", 64'(done_cnt), 64'd5);
    chk("full_ost_0", 64'(ost_cnt), 64'd0);
    chk("full_errs", 64'({err_last, err_resp}), 64'd0);

    // Backpressure, delayed AR and a push coinciding with the final pop.
    do_reset();
    base = pulses;
    issue_cmd(4'd6, 32'h600, 8'd2, 3'd2, AXI_BURST_INCR);
    accept_ar(4'd6, 32'h600, 8'd2, 3'd2, AXI_BURST_INCR, 3);
    send_beats(4'd6, 0, 2, 3, -1, 1);
    cmd_id = 4'd7; cmd_addr = 32'h700; cmd_len = 8'd1; cmd_size = 3'd2;
    cmd_burst = AXI_BURST_INCR; cmd_valid = 1'b1;
    axi.rdata = beat_data(4'd6, 2); axi.rresp = AXI_RESP_OK; axi.rlast = 1'b1; axi.rvalid = 1'b1;
    #1;
    chk("conc_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("conc_rready", 64'(axi.rready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    chk("conc_ost_same", 64'(ost_cnt), 64'd1);
    chk("conc_last", 64'(usr_rd_last), 64'd1);
    chk("conc_id", 64'(usr_rd_id), 64'd6);
    chk("conc_done1", 64'(done_cnt), 64'd1);
    accept_ar(4'd7, 32'h700, 8'd1, 3'd2, AXI_BURST_INCR, 3);
    send_beats(4'd7, 0, 2, 2, -1, 1);
    chk("conc_done2", 64'(done_cnt), 64'd2);
    chk("conc_ost_0", 64'(ost_cnt), 64'd0);
    chk("conc_errs", 64'({err_last, err_resp}), 64'd0);
    @(posedge clk); #1;
    chk("conc_pulses", 64'(pulses - base), 64'd5);

    // Reset during beat 2 of a len=7 burst, then a fresh single-beat burst.
    do_reset();
    issue_cmd(4'd9, 32'h900, 8'd7, 3'd2, AXI_BURST_INCR);
    accept_ar(4'd9, 32'h900, 8'd7, 3'd2, AXI_BURST_INCR, 0);
    send_beats(4'd9, 0, 1, 8, -1, 0);
    axi.rdata = beat_data(4'd9, 1); axi.rvalid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_vals("mid");
    axi.rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    issue_cmd(4'd10, 32'hA00, 8'd0, 3'd2, AXI_BURST_INCR);
    accept_ar(4'd10, 32'hA00, 8'd0, 3'd2, AXI_BURST_INCR, 0);
    send_beats(4'd10, 0, 1, 1, -1, 0);
    chk("mid_done", 64'(done_cnt), 64'd1);
    chk("mid_ost_0", 64'(ost_cnt), 64'd0);
    chk("mid_errs", 64'({err_last, err_resp}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
